// File: rtl/my_nios1_nios2_oci_access_arbiter_if.sv
// Bundle of both requester ports plus the OCI memory port of the access arbiter.
// The slave modport is the arbiter view, the master modport the environment view.
interface my_nios1_nios2_oci_access_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              a_req;
    logic              a_write;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_write;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    logic              b_lock;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner_b;

    modport slave (
        input  a_req, a_write, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_write, b_addr, b_wdata, b_lock,
        output b_ack, b_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata,
        output busy, owner_b
    );

    modport master (
        output a_req, a_write, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_write, b_addr, b_wdata, b_lock,
        input  b_ack, b_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata,
        input  busy, owner_b
    );
endinterface

// File: rtl/my_nios1_nios2_oci_access_arbiter.sv
// Round-robin arbiter sharing the OCI debug memory port between JTAG (A) and Avalon (B).
// Define OCI_ARB_LOCK_EN to let a locked B sequence keep the port until it unlocks.
module my_nios1_nios2_oci_access_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input logic clk,
    input logic reset,
    my_nios1_nios2_oci_access_arbiter_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GRANT  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_ACK    = 3'd4;

    logic [2:0]        state;
    logic              l_write;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic [1:0]        cnt;
    logic              owner_q;
    logic              pick_b;
    logic              any_req;

    assign any_req     = bus.a_req | bus.b_req;
    assign bus.busy    = (state != S_IDLE);
    assign bus.owner_b = owner_q;

`ifdef OCI_ARB_LOCK_EN
    logic lock_q;

    // lock_q remembers whether the last B grant asked to keep the port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q <= 1'b0;
        end else if (state == S_IDLE && any_req && pick_b) begin
            lock_q <= bus.b_lock;
        end
    end

    assign pick_b = bus.b_req & (~bus.a_req | ~owner_q | lock_q);
`else
    logic unused_lock;

    assign unused_lock = bus.b_lock;
    assign pick_b      = bus.b_req & (~bus.a_req | ~owner_q);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            l_write       <= 1'b0;
            l_addr        <= '0;
            l_wdata       <= '0;
            cnt           <= 2'd0;
            owner_q       <= 1'b1;
            bus.a_ack     <= 1'b0;
            bus.b_ack     <= 1'b0;
            bus.a_rdata   <= '0;
            bus.b_rdata   <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_re    <= 1'b0;
        end else begin
            bus.a_ack  <= 1'b0;
            bus.b_ack  <= 1'b0;
            bus.mem_we <= 1'b0;
            bus.mem_re <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        state   <= S_GRANT;
                        owner_q <= pick_b;
                        l_write <= pick_b ? bus.b_write : bus.a_write;
                        l_addr  <= pick_b ? bus.b_addr  : bus.a_addr;
                        l_wdata <= pick_b ? bus.b_wdata : bus.a_wdata;
                    end
                end
                S_GRANT: begin
                    // strobes are registered so they land in the ACCESS cycle
                    state         <= S_ACCESS;
                    bus.mem_addr  <= l_addr;
                    bus.mem_wdata <= l_wdata;
                    bus.mem_we    <= l_write;
                    bus.mem_re    <= ~l_write;
                end
                S_ACCESS: begin
                    if (l_write) begin
                        state     <= S_ACK;
                        bus.a_ack <= ~owner_q;
                        bus.b_ack <= owner_q;
                    end else begin
                        state <= S_WAIT;
                        cnt   <= 2'(RD_LAT);
                    end
                end
                S_WAIT: begin
                    if (cnt == 2'd1) begin
                        state     <= S_ACK;
                        bus.a_ack <= ~owner_q;
                        bus.b_ack <= owner_q;
                        if (owner_q) bus.b_rdata <= bus.mem_rdata;
                        else         bus.a_rdata <= bus.mem_rdata;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
